keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan controller for the 12-input keypad select mux.
//  - Steps the mux select through keys 0..11 and samples the single mux output once per key slot.
//  - Debounces the 12-key snapshot across whole scan frames.
//  - Emits one key code per new press through a valid/ready output register.
//  - Sits between the keypad mux and the digit/command logic of the launchpad.
// PARAMETERS
//  SETTLE_CYCLES    4  cycles per key slot, including the sample cycle; legal range >=2
//  DEBOUNCE_FRAMES  3  consecutive identical frames required to accept a change; legal range >=1
// PORTS
//  clk         in   1  single clock; every register is rising-edge
//  rst         in   1  synchronous, active-high reset
//  scan_en     in   1  1 = scanning runs; 0 = scanning frozen
//  mux_sel     out  4  drives the mux select input
//                       0-9 = digit keys D0-D9, 10 = star key, 11 = sharp key
//  mux_out     in   1  mux data output, 1 = selected key pressed
//  key_valid   out  1  key_code holds an unconsumed press event
//  key_code    out  4  0-9 digit, 10 = star, 11 = sharp
//  key_ready   in   1  consumer accepts key_code when key_valid=1 and key_ready=1
//  key_held    out  1  1 while any key is pressed in the debounced vector
//  overflow    out  1  sticky; set when a press event is dropped
// BEHAVIOUR
//  Reset values
//   - mux_sel=0, key_valid=0, key_code=0, key_held=0, overflow=0.
//   - Slot counter=0, frame shadow=0, stable vector=0, debounce count=0.
//   - rst takes priority over all other inputs in every state, including mid-slot and mid-frame.
//   - After rst, scanning restarts at sel 0.
//  Scanning (FSM states SCAN and FRAME_END; state is SCAN when scan_en=0)
//   - Each slot is SETTLE_CYCLES cycles long; mux_sel is constant for the whole slot.
//   - mux_out is registered into shadow[mux_sel] on the last cycle of the slot.
//   - mux_sel then steps 0->1->...->11 and wraps from 11 to 0.
//   - Values 12-15 are never driven.
//   - One frame = 12*SETTLE_CYCLES cycles; 48 cycles at the defaults.
//   - FRAME_END lasts 1 cycle, entered after the sel 11 sample; mux_sel is already 0 in this cycle.
//   - Total frame period = 12*SETTLE_CYCLES+1 cycles; 49 at the defaults.
//  Debounce (evaluated in FRAME_END)
//   - shadow == previous shadow: cnt = min(cnt+1, DEBOUNCE_FRAMES).
//   - Otherwise: cnt = 1.
//   - When cnt reaches DEBOUNCE_FRAMES, stable <= shadow.
//   - key_held = |stable, registered; it updates in the cycle after FRAME_END.
//  Press events
//   - rise = shadow & ~stable, taken in the FRAME_END cycle that updates stable.
//   - If rise != 0, event code = lowest set index.
//   - Other keys rising in the same frame are discarded silently.
//   - Releases produce no event.
//   - A key held continuously produces exactly one event.
//  Output handshake
//   - key_valid=1 and key_ready=1: accept; key_valid falls next cycle unless a new event loads.
//   - A new event loads key_code and sets key_valid next cycle when key_valid=0 or key_ready=1 (same-cycle accept).
//   - key_code stays stable while key_valid=1 and key_ready=0.
//   - Event while key_valid=1 and key_ready=0: the event is dropped, overflow<=1, and the pending code is kept.
//   - overflow clears only on rst.
//  scan_en
//   - Deassert: the next cycle forces mux_sel=0, slot counter=0, FSM=SCAN.
//   - The partial frame is discarded; shadow is cleared.
//   - stable, cnt, key_held and pending output are kept.
//   - The handshake keeps working while scan_en=0.
//   - Reassert: the frame starts at sel 0.
// TESTING
//  Defaults throughout (SETTLE=4, DEBOUNCE=3), plus a bench mux model driven by 12 key lines.
//  1 Key 5 held for 6 frames, key_ready=1 -> one key_valid pulse with key_code=5 at the 3rd FRAME_END after the press frame.
//    key_held=1 until 3 frames after release; no second event.
//  2 Key 7 asserted for 1 frame only (bounce) -> no key_valid; key_held stays 0; stable stays 0.
//  3 Keys 3 and 10 pressed in the same frame -> single event key_code=3.
//    Release both, then press 11 -> key_code=11.
//  4 key_ready=0, press 2, release, then press 4 -> key_code stays 2 and overflow=1.
//    Then key_ready=1 -> key_valid drops for 1 cycle; overflow stays 1 until rst.
//  5 rst pulsed mid-slot at mux_sel=6 with key 9 stable -> next cycle all outputs 0.
//    Scan restarts at sel 0; key 9, still held, re-reports after 3 frames.
//  6 scan_en=0 at mux_sel=8 for 20 cycles, then 1 -> mux_sel=0 during the pause.
//    The frame restarts at 0; stable is unchanged; a pending key_valid is still accepted during the pause.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//   Walks the 12-input keypad mux select through keys 0..11 and samples the
//   mux output once per key slot. Whole-frame snapshots are debounced, and
//   each new press is reported as one key code through a valid/ready output
//   register.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_scan_en    1 = scanning runs, 0 = scanning frozen at sel 0
//   o_mux_sel    mux select (0-9 digits, 10 star, 11 sharp)
//   i_mux_out    mux data, 1 = selected key pressed
//   o_key_valid  o_key_code holds an unconsumed press event
//   o_key_code   reported key (0-9 digit, 10 star, 11 sharp)
//   i_key_ready  consumer accepts o_key_code when o_key_valid is high
//   o_key_held   any key pressed in the debounced vector
//   o_overflow   sticky flag, a press event was dropped
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scan_en,
  output logic [3:0] o_mux_sel,
  input  logic       i_mux_out,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  input  logic       i_key_ready,
  output logic       o_key_held,
  output logic       o_overflow
);

  localparam int unsigned NUM_KEYS = 12;
  localparam int unsigned SLOT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [3:0]        SEL_LAST  = 4'(NUM_KEYS - 1);

  typedef enum logic {
    ST_SCAN      = 1'b0,
    ST_FRAME_END = 1'b1
  } state_t;

  state_t                r_state,       w_state_nxt;
  logic [SLOT_W-1:0]     r_slot_cnt,    w_slot_cnt_nxt;
  logic [3:0]            r_mux_sel,     w_mux_sel_nxt;
  logic [NUM_KEYS-1:0]   r_shadow,      w_shadow_nxt;
  logic [NUM_KEYS-1:0]   r_prev_shadow, w_prev_shadow_nxt;
  logic [NUM_KEYS-1:0]   r_stable,      w_stable_nxt;
  logic [CNT_W-1:0]      r_cnt,         w_cnt_nxt;
  logic                  r_key_valid,   w_key_valid_nxt;
  logic [3:0]            r_key_code,    w_key_code_nxt;
  logic                  r_key_held,    w_key_held_nxt;
  logic                  r_overflow,    w_overflow_nxt;

  logic [NUM_KEYS-1:0]   w_rise;
  logic                  w_event;
  logic [3:0]            w_event_code;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, scan/debounce datapath and output handshake
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_cnt_nxt    = r_slot_cnt;
    w_mux_sel_nxt     = r_mux_sel;
    w_shadow_nxt      = r_shadow;
    w_prev_shadow_nxt = r_prev_shadow;
    w_stable_nxt      = r_stable;
    w_cnt_nxt         = r_cnt;
    w_key_valid_nxt   = r_key_valid;
    w_key_code_nxt    = r_key_code;
    w_overflow_nxt    = r_overflow;
    w_rise            = '0;
    w_event           = 1'b0;
    w_event_code      = 4'd0;

    // Accepted code retires unless a new event reloads below
    if (r_key_valid && i_key_ready) begin
      w_key_valid_nxt = 1'b0;
    end

    if (!i_scan_en) begin
      // Frozen: discard the partial frame, keep debounce history and output
      w_state_nxt    = ST_SCAN;
      w_slot_cnt_nxt = '0;
      w_mux_sel_nxt  = 4'd0;
      w_shadow_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_SCAN: begin
          if (r_slot_cnt == SLOT_LAST) begin
            w_slot_cnt_nxt = '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
              if (r_mux_sel == 4'(i)) begin
                w_shadow_nxt[i] = i_mux_out;
              end
            end
            if (r_mux_sel == SEL_LAST) begin
              w_mux_sel_nxt = 4'd0;
              w_state_nxt   = ST_FRAME_END;
            end else begin
              w_mux_sel_nxt = r_mux_sel + 4'd1;
            end
          end else begin
            w_slot_cnt_nxt = r_slot_cnt + SLOT_W'(1);
          end
        end

        ST_FRAME_END: begin
          w_state_nxt       = ST_SCAN;
          w_prev_shadow_nxt = r_shadow;
          if (r_shadow == r_prev_shadow) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
          end else begin
            w_cnt_nxt = CNT_W'(1);
          end
          if (w_cnt_nxt == CNT_MAX) begin
            w_stable_nxt = r_shadow;
            w_rise       = r_shadow & ~r_stable;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
        end
      endcase
    end

    // Lowest rising index wins; other simultaneous rises are dropped
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_event      = 1'b1;
        w_event_code = 4'(i);
      end
    end

    if (w_event) begin
      if (!r_key_valid || i_key_ready) begin
        w_key_valid_nxt = 1'b1;
        w_key_code_nxt  = w_event_code;
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end

    // Tracks the debounced vector as it will be after this edge
    w_key_held_nxt = |w_stable_nxt;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_cnt    <= '0;
      r_mux_sel     <= 4'd0;
      r_shadow      <= '0;
      r_prev_shadow <= '0;
      r_stable      <= '0;
      r_cnt         <= '0;
      r_key_valid   <= 1'b0;
      r_key_code    <= 4'd0;
      r_key_held    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_slot_cnt    <= w_slot_cnt_nxt;
      r_mux_sel     <= w_mux_sel_nxt;
      r_shadow      <= w_shadow_nxt;
      r_prev_shadow <= w_prev_shadow_nxt;
      r_stable      <= w_stable_nxt;
      r_cnt         <= w_cnt_nxt;
      r_key_valid   <= w_key_valid_nxt;
      r_key_code    <= w_key_code_nxt;
      r_key_held    <= w_key_held_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  assign o_mux_sel   = r_mux_sel;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_key_held  = r_key_held;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//   Bench for keypad_scan_ctrl at default parameters. A 12-line key model feeds
//   the mux; a frame-level reference model pushes expected key codes into a
//   scoreboard queue, and a monitor pops them on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int FRAME_LEN = 49;
  localparam int DEB       = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        key_ready;
  logic [11:0] keys;
  logic [3:0]  mux_sel;
  logic        mux_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        overflow;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scan_en  (scan_en),
    .o_mux_sel  (mux_sel),
    .i_mux_out  (mux_out),
    .o_key_valid(key_valid),
    .o_key_code (key_code),
    .i_key_ready(key_ready),
    .o_key_held (key_held),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  // Keypad mux model
  assign mux_out = (mux_sel < 4'd12) ? keys[mux_sel] : 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned exp_q[$];

  // Frame-level reference state
  logic [11:0] m_prev;
  logic [11:0] m_stable;
  int          m_cnt;
  bit          m_valid;
  bit          m_ovf;
  int unsigned m_code;
  int          fcyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned lowest(input logic [11:0] v);
    int unsigned r = 0;
    for (int i = 11; i >= 0; i--) if (v[i]) r = 32'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_prev   = '0;
    m_stable = '0;
    m_cnt    = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_code   = 0;
    exp_q.delete();
  endtask

  // Reference update for a completed frame, then compare the post-FRAME_END outputs
  task automatic end_frame();
    logic [11:0] rise;
    if (keys == m_prev) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
    else                m_cnt = 1;
    m_prev = keys;
    if (m_cnt == DEB) begin
      rise     = keys & ~m_stable;
      m_stable = keys;
      if (rise != 12'd0) begin
        if (m_valid) begin
          m_ovf = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_code  = lowest(rise);
          exp_q.push_back(m_code);
        end
      end
    end
    check("frame_held", 32'(key_held), 32'(|m_stable));
    check("frame_ovf", 32'(overflow), 32'(m_ovf));
    check("frame_valid", 32'(key_valid), 32'(m_valid));
    if (m_valid) check("frame_code", 32'(key_code), m_code);
  endtask

  // One clock of scanning, with select-sequence checks
  task automatic tick();
    if (fcyc == FRAME_LEN - 1)  check("sel_frame_end", 32'(mux_sel), 32'd0);
    else if (fcyc % 4 == 2)     check("sel_slot", 32'(mux_sel), 32'(fcyc / 4));
    if (key_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
    if (fcyc == FRAME_LEN - 1) begin
      fcyc = 0;
      end_frame();
    end else begin
      fcyc++;
    end
  endtask

  task automatic frames(input logic [11:0] k, input int n);
    keys = k;
    repeat (n) begin
      do tick(); while (fcyc != 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    fcyc = 0;
    model_reset();
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected code
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (exp_q.size() == 0) check("spurious_accept", 32'(key_valid), 32'd0);
      else                   check("accept_code", 32'(key_code), exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    scan_en   = 1'b1;
    key_ready = 1'b1;
    keys      = '0;
    fcyc      = 0;
    model_reset();
    do_reset();

    // Held key 5: one event, held until debounced release
    frames(12'(1 << 5), 6);
    frames(12'd0, 4);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Single-frame bounce on key 7
    frames(12'(1 << 7), 1);
    frames(12'd0, 3);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous 3 and 10 -> 3; then 11
    frames(12'((1 << 3) | (1 << 10)), 3);
    frames(12'd0, 3);
    frames(12'(1 << 11), 3);
    frames(12'd0, 3);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: pending 2, dropped 4 raises overflow
    key_ready = 1'b0;
    frames(12'(1 << 2), 3);
    frames(12'd0, 3);
    frames(12'(1 << 4), 3);
    check("t4_code_kept", 32'(key_code), 32'd2);
    check("t4_overflow", 32'(overflow), 32'd1);
    key_ready = 1'b1;
    tick();
    check("t4_valid_drop", 32'(key_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    frames(12'(1 << 4), 1);
    frames(12'd0, 3);
    check("t4_ovf_still", 32'(overflow), 32'd1);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-slot with key 9 stable, then re-report
    frames(12'(1 << 9), 4);
    check("t5_held_pre", 32'(key_held), 32'd1);
    repeat (25) tick();
    check("t5_sel_mid", 32'(mux_sel), 32'd6);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    do_reset();
    frames(12'(1 << 9), 3);
    frames(12'd0, 3);
    check("t5_sb_done", 32'(exp_q.size()), 32'd0);

    // scan_en pause at sel 8 with a pending code accepted during the pause
    key_ready = 1'b0;
    frames(12'(1 << 1), 3);
    repeat (33) tick();
    check("t6_sel_pre", 32'(mux_sel), 32'd8);
    scan_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("t6_sel_pause", 32'(mux_sel), 32'd0);
      check("t6_held_pause", 32'(key_held), 32'd1);
      if (i == 4) begin
        key_ready = 1'b1;
        m_valid   = 1'b0;
      end
      if (i == 6) check("t6_valid_pause", 32'(key_valid), 32'd0);
    end
    scan_en = 1'b1;
    fcyc    = 0;
    frames(12'(1 << 1), 2);
    frames(12'd0, 3);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
